// File: rtl/grid_merge_engine.sv
// grid_merge_engine: cursor-driven grid of cell values. Two cells are picked
// with btn_ok; the first becomes (a+b) mod MOD and the second is cleared.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   btn_up/down/left/right    one-cycle cursor moves (priority up>down>left>right)
//   btn_ok                    select / confirm / cancel pulse
//   mode                      (GRID_MERGE_SUB_EN only) 1 = subtract, 0 = add
//   load, load_data           load strobe and new grid contents
//   cells                     current grid, cell k at [k*DW +: DW]
//   cursor                    cursor cell index (row*COLS+col)
//   sel_valid, sel_idx        first operand held and its index
//   busy                      high while the write-back cycle is pending
//   merge_done, merge_count   completion pulse and saturating merge counter
//
// Optional feature: define GRID_MERGE_SUB_EN to add the mode port and
// the (a+MOD-b) mod MOD operation.
module grid_merge_engine #(
  parameter int unsigned ROWS = 2,
  parameter int unsigned COLS = 5,
  parameter int unsigned DW   = 4,
  parameter int unsigned MOD  = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      btn_up,
  input  logic                      btn_down,
  input  logic                      btn_left,
  input  logic                      btn_right,
  input  logic                      btn_ok,
`ifdef GRID_MERGE_SUB_EN
  input  logic                      mode,
`endif
  input  logic                      load,
  input  logic [ROWS*COLS*DW-1:0]   load_data,
  output logic [ROWS*COLS*DW-1:0]   cells,
  output logic [7:0]                cursor,
  output logic                      sel_valid,
  output logic [7:0]                sel_idx,
  output logic                      busy,
  output logic                      merge_done,
  output logic [15:0]               merge_count
);

  localparam int unsigned N     = ROWS * COLS;
  localparam logic [DW:0] MOD_W = (DW+1)'(MOD);

  typedef enum logic [1:0] {IDLE, SEL, WRITE} state_t;

  state_t      state;
  logic [7:0]  b_idx;
  logic        sub_q;
  logic [7:0]  move_cursor;
  int unsigned cur_i;
  int unsigned cur_row;
  int unsigned cur_col;
  logic [DW-1:0] a_val;
  logic [DW-1:0] b_val;
  logic [DW:0]   wide;
  logic [DW-1:0] result;

  assign cur_i   = 32'(cursor);
  assign cur_row = cur_i / COLS;
  assign cur_col = cur_i % COLS;

  // Cursor after this cycle's move; vertical moves wrap within the column,
  // horizontal moves wrap over the linear index.
  always_comb begin
    move_cursor = cursor;
    if (btn_up)
      move_cursor = (cur_row == 0) ? 8'(cur_i + (ROWS-1)*COLS) : 8'(cur_i - COLS);
    else if (btn_down)
      move_cursor = (cur_row == ROWS-1) ? 8'(cur_col) : 8'(cur_i + COLS);
    else if (btn_left)
      move_cursor = (cur_i == 0) ? 8'(N-1) : 8'(cur_i - 1);
    else if (btn_right)
      move_cursor = (cur_i == N-1) ? 8'd0 : 8'(cur_i + 1);
  end

  assign a_val = cells[32'(sel_idx)*DW +: DW];
  assign b_val = cells[32'(b_idx)*DW +: DW];

  // Merge result at DW+1 bits; loaded operands may be >= MOD, so a full modulo is used.
  always_comb begin
    wide = {1'b0, a_val} + {1'b0, b_val};
    if (sub_q)
      wide = {1'b0, a_val} + MOD_W - {1'b0, b_val};
    result = DW'(wide % MOD_W);
  end

  // Control FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cells       <= '0;
      cursor      <= '0;
      sel_idx     <= '0;
      sel_valid   <= 1'b0;
      b_idx       <= '0;
      sub_q       <= 1'b0;
      busy        <= 1'b0;
      merge_done  <= 1'b0;
      merge_count <= '0;
    end else if (load) begin
      state      <= IDLE;
      cells      <= load_data;
      cursor     <= '0;
      sel_valid  <= 1'b0;
      busy       <= 1'b0;
      merge_done <= 1'b0;
    end else begin
      merge_done <= 1'b0;
      case (state)
        IDLE: begin
          cursor <= move_cursor;
          if (btn_ok) begin
            sel_idx   <= cursor;
            sel_valid <= 1'b1;
            state     <= SEL;
          end
        end
        SEL: begin
          cursor <= move_cursor;
          if (btn_ok) begin
            if (cursor == sel_idx) begin
              sel_valid <= 1'b0;
              state     <= IDLE;
            end else begin
              b_idx <= cursor;
`ifdef GRID_MERGE_SUB_EN
              sub_q <= mode;
`else
              sub_q <= 1'b0;
`endif
              busy  <= 1'b1;
              state <= WRITE;
            end
          end
        end
        WRITE: begin
          cells[32'(sel_idx)*DW +: DW] <= result;
          cells[32'(b_idx)*DW +: DW]   <= '0;
          sel_valid  <= 1'b0;
          busy       <= 1'b0;
          merge_done <= 1'b1;
          if (merge_count != 16'hFFFF)
            merge_count <= merge_count + 16'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_merge_engine.sv
// Bench for grid_merge_engine (ROWS=2, COLS=5, DW=4, MOD=10): directed
// stimulus pushes expected merge results into a queue; a monitor pops and
// compares them whenever merge_done is presented.
module tb_grid_merge_engine;

  localparam int unsigned GW = 40;

  logic          clk;
  logic          rst;
  logic          btn_up, btn_down, btn_left, btn_right, btn_ok;
`ifdef GRID_MERGE_SUB_EN
  logic          mode;
`endif
  logic          load;
  logic [GW-1:0] load_data;
  logic [GW-1:0] cells;
  logic [7:0]    cursor;
  logic          sel_valid;
  logic [7:0]    sel_idx;
  logic          busy;
  logic          merge_done;
  logic [15:0]   merge_count;

  typedef struct {
    logic [GW-1:0] cells;
    logic [15:0]   count;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors;
  int   miscompares;

  grid_merge_engine dut (
    .clk         (clk),
    .rst         (rst),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_ok      (btn_ok),
`ifdef GRID_MERGE_SUB_EN
    .mode        (mode),
`endif
    .load        (load),
    .load_data   (load_data),
    .cells       (cells),
    .cursor      (cursor),
    .sel_valid   (sel_valid),
    .sel_idx     (sel_idx),
    .busy        (busy),
    .merge_done  (merge_done),
    .merge_count (merge_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Drive one cycle of button pulses, then release them.
  task automatic press(input logic u, input logic d, input logic l, input logic r, input logic o);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_ok = o;
    @(posedge clk); #1;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_ok = 0;
  endtask

  task automatic do_load(input logic [GW-1:0] d);
    load = 1'b1; load_data = d;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic push_exp(input logic [GW-1:0] c, input logic [15:0] n);
    exp_t e;
    e.cells = c;
    e.count = n;
    exp_q.push_back(e);
  endtask

  // Monitor: every merge_done cycle must match the oldest expectation.
  always @(negedge clk) begin
    if (merge_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_merge_done", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("merge_cells", 64'(cells), 64'(mon_e.cells));
        check("merge_count", 64'(merge_count), 64'(mon_e.count));
        check("merge_busy_low", 64'(busy), 64'd0);
      end
    end
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_ok = 0;
`ifdef GRID_MERGE_SUB_EN
    mode = 1'b0;
`endif
    // Reset asserted together with load and ok: reset must win.
    rst = 1'b1; load = 1'b1; load_data = 40'h1234512345; btn_ok = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; load = 1'b0; btn_ok = 1'b0;
    check("rst_cells", 64'(cells), 64'd0);
    check("rst_cursor", 64'(cursor), 64'd0);
    check("rst_sel_valid", 64'(sel_valid), 64'd0);
    check("rst_sel_idx", 64'(sel_idx), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_merge_done", 64'(merge_done), 64'd0);
    check("rst_merge_count", 64'(merge_count), 64'd0);

    // Basic add merge: 1 + 6 -> cells[1]=7, cells[6]=0.
    do_load(40'h9876543210);
    check("load_cells", 64'(cells), 64'h9876543210);
    check("load_cursor", 64'(cursor), 64'd0);
    press(0, 0, 0, 1, 0);
    check("right_0", 64'(cursor), 64'd1);
    press(0, 0, 0, 0, 1);
    check("sel_valid_set", 64'(sel_valid), 64'd1);
    check("sel_idx_1", 64'(sel_idx), 64'd1);
    press(0, 1, 0, 0, 0);
    check("down_1", 64'(cursor), 64'd6);
    push_exp(40'h9870543270, 16'd1);
    press(0, 0, 0, 0, 1);
    check("busy_in_write", 64'(busy), 64'd1);
    // Buttons during the write cycle are ignored.
    press(0, 0, 0, 1, 1);
    check("write_ignores_move", 64'(cursor), 64'd6);
    check("write_sel_cleared", 64'(sel_valid), 64'd0);
    check("write_busy_low", 64'(busy), 64'd0);

    // Cursor wrapping and move priority.
    do_load(40'h9876543210);
    press(0, 0, 1, 0, 0);
    check("left_wrap", 64'(cursor), 64'd9);
    press(0, 0, 0, 1, 0);
    check("right_wrap", 64'(cursor), 64'd0);
    press(0, 0, 0, 1, 0);
    press(0, 0, 0, 1, 0);
    press(1, 1, 1, 1, 0);
    check("up_priority_wrap", 64'(cursor), 64'd7);
    press(0, 1, 0, 0, 0);
    check("down_wrap", 64'(cursor), 64'd2);

    // ok with a same-cycle move uses the old cursor; ok on the same cell cancels.
    press(0, 0, 0, 1, 0);
    press(0, 0, 0, 1, 1);
    check("ok_old_cursor", 64'(sel_idx), 64'd3);
    check("ok_move_applies", 64'(cursor), 64'd4);
    press(0, 0, 1, 0, 0);
    press(0, 0, 0, 0, 1);
    check("cancel_sel_valid", 64'(sel_valid), 64'd0);
    check("cancel_cells", 64'(cells), 64'h9876543210);
    check("cancel_count", 64'(merge_count), 64'd1);

    // Modulo wrap 9 + 8 -> 7; a loaded 0xF cell stays untouched.
    do_load(40'hF876843219);
    check("load_big_value", 64'(cells), 64'hF876843219);
    press(0, 0, 0, 0, 1);
    press(0, 1, 0, 0, 0);
    push_exp(40'hF876043217, 16'd2);
    press(0, 0, 0, 0, 1);
    press(0, 0, 0, 0, 0);
    check("mod_cursor", 64'(cursor), 64'd5);

    // Load during SEL overrides ok and clears the selection.
    press(0, 0, 0, 0, 1);
    check("sel_before_load", 64'(sel_valid), 64'd1);
    btn_ok = 1'b1;
    do_load(40'h1111111111);
    btn_ok = 1'b0;
    check("load_sel_cleared", 64'(sel_valid), 64'd0);
    check("load_sel_cursor", 64'(cursor), 64'd0);
    check("load_sel_cells", 64'(cells), 64'h1111111111);
    repeat (2) press(0, 0, 0, 0, 0);

    // Reset during WRITE aborts the merge.
    do_load(40'h9876543210);
    press(0, 0, 0, 1, 0);
    press(0, 0, 0, 0, 1);
    press(0, 1, 0, 0, 0);
    press(0, 0, 0, 0, 1);
    check("busy_before_abort", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_cells", 64'(cells), 64'd0);
    check("abort_cursor", 64'(cursor), 64'd0);
    check("abort_sel_valid", 64'(sel_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_count", 64'(merge_count), 64'd0);
    repeat (3) press(0, 0, 0, 0, 0);

`ifdef GRID_MERGE_SUB_EN
    // Subtract: a=3, b=5 -> (3+10-5) mod 10 = 8.
    do_load(40'h9876543210);
    repeat (3) press(0, 0, 0, 1, 0);
    press(0, 0, 0, 0, 1);
    repeat (2) press(0, 0, 0, 1, 0);
    mode = 1'b1;
    push_exp(40'h9876048210, 16'd1);
    press(0, 0, 0, 0, 1);
    mode = 1'b0;
    press(0, 0, 0, 0, 0);
`endif

    repeat (3) press(0, 0, 0, 0, 0);
    check("pending_expectations", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
